apb_arbiter: RTL and testbench

Two-master APB arbiter and bridge between the `Sampler`/`Computer` masters and the `Memory` slave. It replaces the OR-combined shared bus with a single owned transfer at a time. The block latches the winning master's setup phase and replays it as a clean APB SETUP/ACCESS sequence to the slave. It returns `prdata`/`pready`/`pslverr` only to the granted master and stalls the other with `pready` low.

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_arb_grant.sv | 52 +++++
 rtl/apb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_apb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and constants for the two-master APB arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  localparam int M_SAMPLER  = 0;
  localparam int M_COMPUTER = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

`default_nettype wire

// File: rtl/apb_arb_grant.sv
// ============================================================================
//  Module      : apb_arb_grant
//  Description : Round-robin winner select with last-served pointer.
//                Only built when APB_ARB_RR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef APB_ARB_RR_EN
module apb_arb_grant
  import apb_pkg::*;
(
  input  logic       pclk_i,
  input  logic       preset_i,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_idx_i,
  output logic [1:0] gnt_o
);

  // Index of the master served most recently; ties go to the other one.
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (done_i) begin
      last_d = done_idx_i;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      last_q <= 1'(M_SAMPLER);
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule
`endif

`default_nettype wire

// File: rtl/apb_arbiter.sv
// ============================================================================
//  Module      : apb_arbiter
//  Description : Two-master APB arbiter/bridge; latches the winner's setup
//                phase and replays it as SETUP/ACCESS to a single slave.
//                APB_ARB_RR_EN selects round-robin, else fixed priority (m0).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) (
  input  logic              pclk_i,
  input  logic              preset_i,

  input  logic              m0_psel_i,
  input  logic              m0_penable_i,
  input  logic              m0_pwrite_i,
  input  logic [ADDR_W-1:0] m0_paddr_i,
  input  logic [DATA_W-1:0] m0_pwdata_i,
  output logic [DATA_W-1:0] m0_prdata_o,
  output logic              m0_pready_o,
  output logic              m0_pslverr_o,

  input  logic              m1_psel_i,
  input  logic              m1_penable_i,
  input  logic              m1_pwrite_i,
  input  logic [ADDR_W-1:0] m1_paddr_i,
  input  logic [DATA_W-1:0] m1_pwdata_i,
  output logic [DATA_W-1:0] m1_prdata_o,
  output logic              m1_pready_o,
  output logic              m1_pslverr_o,

  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,

  output logic [1:0]        grant_o
);

  apb_state_t        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic [1:0]        req;
  logic [1:0]        win;
  logic              done;
  logic              in_access;

  // Masters' penable is irrelevant to arbitration: only psel requests.
  logic              unused_penable;
  assign unused_penable = m0_penable_i ^ m1_penable_i;

  assign req       = {m1_psel_i, m0_psel_i};
  assign in_access = (state_q == ACCESS);
  assign done      = in_access & pready_i;

`ifdef APB_ARB_RR_EN
  apb_arb_grant u_grant (
    .pclk_i     (pclk_i),
    .preset_i   (preset_i),
    .req_i      (req),
    .done_i     (done),
    .done_idx_i (grant_q[M_COMPUTER]),
    .gnt_o      (win)
  );
`else
  always_comb begin
    win = 2'b00;
    if (req[M_SAMPLER]) begin
      win[M_SAMPLER] = 1'b1;
    end else if (req[M_COMPUTER]) begin
      win[M_COMPUTER] = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    case (state_q)
      IDLE: begin
        if (|win) begin
          state_d   = SETUP;
          grant_d   = win;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          if (win[M_COMPUTER]) begin
            pwrite_d = m1_pwrite_i;
            paddr_d  = m1_paddr_i;
            pwdata_d = m1_pwdata_i;
          end else begin
            pwrite_d = m0_pwrite_i;
            paddr_d  = m0_paddr_i;
            pwdata_d = m0_pwdata_i;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // Completion always leaves one IDLE cycle before the next grant.
        if (done) begin
          state_d   = IDLE;
          grant_d   = 2'b00;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        grant_d   = 2'b00;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign grant_o   = grant_q;

  // Slave response is steered to the owner only; the other master sees a stall.
  assign m0_pready_o  = in_access & grant_q[M_SAMPLER] & pready_i;
  assign m0_prdata_o  = grant_q[M_SAMPLER] ? prdata_i : '0;
  assign m0_pslverr_o = grant_q[M_SAMPLER] & pready_i & pslverr_i;

  assign m1_pready_o  = in_access & grant_q[M_COMPUTER] & pready_i;
  assign m1_prdata_o  = grant_q[M_COMPUTER] ? prdata_i : '0;
  assign m1_pslverr_o = grant_q[M_COMPUTER] & pready_i & pslverr_i;

endmodule

`default_nettype wire

// File: tb/tb_apb_arbiter.sv
// ============================================================================
//  Module      : tb_apb_arbiter
//  Description : Scoreboard bench for apb_arbiter (fixed or round-robin build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_arbiter;
  import apb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          pclk_i   = 1'b0;
  logic          preset_i = 1'b1;

  logic          m0_psel_i, m0_penable_i, m0_pwrite_i;
  logic [AW-1:0] m0_paddr_i;
  logic [DW-1:0] m0_pwdata_i, m0_prdata_o;
  logic          m0_pready_o, m0_pslverr_o;

  logic          m1_psel_i, m1_penable_i, m1_pwrite_i;
  logic [AW-1:0] m1_paddr_i;
  logic [DW-1:0] m1_pwdata_i, m1_prdata_o;
  logic          m1_pready_o, m1_pslverr_o;

  logic          psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [DW-1:0] prdata_i  = '0;
  logic          pready_i  = 1'b0;
  logic          pslverr_i = 1'b0;
  logic [1:0]    grant_o;

  apb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .pclk_i       (pclk_i),
    .preset_i     (preset_i),
    .m0_psel_i    (m0_psel_i),
    .m0_penable_i (m0_penable_i),
    .m0_pwrite_i  (m0_pwrite_i),
    .m0_paddr_i   (m0_paddr_i),
    .m0_pwdata_i  (m0_pwdata_i),
    .m0_prdata_o  (m0_prdata_o),
    .m0_pready_o  (m0_pready_o),
    .m0_pslverr_o (m0_pslverr_o),
    .m1_psel_i    (m1_psel_i),
    .m1_penable_i (m1_penable_i),
    .m1_pwrite_i  (m1_pwrite_i),
    .m1_paddr_i   (m1_paddr_i),
    .m1_pwdata_i  (m1_pwdata_i),
    .m1_prdata_o  (m1_prdata_o),
    .m1_pready_o  (m1_pready_o),
    .m1_pslverr_o (m1_pslverr_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i),
    .grant_o      (grant_o)
  );

  always #5 pclk_i = ~pclk_i;

  int cyc = 0;
  always @(posedge pclk_i) cyc <= cyc + 1;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    logic          ign;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void push_exp(input int m, input logic wr, input logic [AW-1:0] a,
                                   input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                                   input logic err, input logic ign);
    exp_t e;
    e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd; e.err = err; e.ign = ign;
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Slave: answers after slv_wait wait cycles in ACCESS
  int            slv_wait  = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err   = 1'b0;
  int            wcnt      = 0;

  always @(negedge pclk_i) begin
    if (psel_o && penable_o) begin
      if (wcnt >= slv_wait) begin
        pready_i = 1'b1; prdata_i = slv_rdata; pslverr_i = slv_err;
      end else begin
        pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
      end
      wcnt++;
    end else begin
      pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0; wcnt = 0;
    end
  end

  // Monitor: every master pready pops that master's scoreboard queue
  task automatic check_pop(input int m);
    exp_t e;
    if (m == 0) begin
      if (q0.size() == 0) begin chk("m0_unexpected_pready", 32'd1, 32'd0); return; end
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) begin chk("m1_unexpected_pready", 32'd1, 32'd0); return; end
      e = q1.pop_front();
    end
    if (e.ign) return;
    chk("sb_grant",  32'(grant_o),  (m == 0) ? 32'd1 : 32'd2);
    chk("sb_pwrite", 32'(pwrite_o), 32'(e.wr));
    chk("sb_paddr",  32'(paddr_o),  32'(e.addr));
    if (e.wr) chk("sb_pwdata", pwdata_o, e.wdata);
    else      chk("sb_prdata", (m == 0) ? m0_prdata_o : m1_prdata_o, e.rdata);
    chk("sb_pslverr",     32'((m == 0) ? m0_pslverr_o : m1_pslverr_o), 32'(e.err));
    chk("sb_other_prdata", (m == 0) ? m1_prdata_o : m0_prdata_o, 32'd0);
    chk("sb_other_pslverr", 32'((m == 0) ? m1_pslverr_o : m0_pslverr_o), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge pclk_i);
      #2;
      if (m0_pready_o) check_pop(0);
      if (m1_pready_o) check_pop(1);
    end
  end

  task automatic drive(input int m, input logic s, input logic en, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_psel_i = s; m0_penable_i = en; m0_pwrite_i = w; m0_paddr_i = a; m0_pwdata_i = d;
    end else begin
      m1_psel_i = s; m1_penable_i = en; m1_pwrite_i = w; m1_paddr_i = a; m1_pwdata_i = d;
    end
  endtask

  // Master transfer; must be called right at a falling edge. lat = cycles from request to pready.
  task automatic xfer(input int m, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [DW-1:0] rd, input logic err, output int lat);
    int c0;
    bit got;
    push_exp(m, wr, a, wd, rd, err, 1'b0);
    c0  = cyc;
    lat = -1;
    got = 1'b0;
    drive(m, 1'b1, 1'b0, wr, a, wd);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge pclk_i);
      if (k == 0) drive(m, 1'b1, 1'b1, wr, a, wd);
      #2;
      if ((m == 0 && m0_pready_o) || (m == 1 && m1_pready_o)) begin
        got = 1'b1;
        lat = cyc - c0;
      end
    end
    @(negedge pclk_i);
    drive(m, 1'b0, 1'b0, 1'b0, '0, '0);
    if (!got) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  int lat, lat0, lat1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    preset_i = 1'b1;
    repeat (3) @(negedge pclk_i);
    #2;
    chk("rst_psel",    32'(psel_o),    32'd0);
    chk("rst_penable", 32'(penable_o), 32'd0);
    chk("rst_pwrite",  32'(pwrite_o),  32'd0);
    chk("rst_paddr",   32'(paddr_o),   32'd0);
    chk("rst_pwdata",  pwdata_o,       32'd0);
    chk("rst_grant",   32'(grant_o),   32'd0);
    chk("rst_ready",   32'({m0_pready_o, m1_pready_o, m0_pslverr_o, m1_pslverr_o}), 32'd0);
    chk("rst_prdata",  m0_prdata_o | m1_prdata_o, 32'd0);
    @(negedge pclk_i);
    preset_i = 1'b0;

    // m0 write, zero-wait slave, cycle-by-cycle
    @(negedge pclk_i);
    slv_wait = 0;
    push_exp(0, 1'b1, 8'h10, 32'hDEADBEEF, '0, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    @(negedge pclk_i); #2;
    chk("t1_setup_psel",    32'(psel_o),      32'd1);
    chk("t1_setup_penable", 32'(penable_o),   32'd0);
    chk("t1_setup_grant",   32'(grant_o),     32'd1);
    chk("t1_setup_m0rdy",   32'(m0_pready_o), 32'd0);
    drive(0, 1'b1, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    @(negedge pclk_i); #2;
    chk("t1_access_psel",    32'(psel_o),      32'd1);
    chk("t1_access_penable", 32'(penable_o),   32'd1);
    chk("t1_access_m0rdy",   32'(m0_pready_o), 32'd1);
    chk("t1_access_m1rdy",   32'(m1_pready_o), 32'd0);
    @(negedge pclk_i);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    #2;
    chk("t1_idle_psel",  32'(psel_o),  32'd0);
    chk("t1_idle_grant", 32'(grant_o), 32'd0);

    // m1 read with two slave wait states
    @(negedge pclk_i);
    slv_wait = 2; slv_rdata = 32'h12345678;
    xfer(1, 1'b0, 8'h20, '0, 32'h12345678, 1'b0, lat);
    chk("t2_latency", 32'(lat), 32'd4);
    slv_wait = 0;

    // reset during a stalled ACCESS
    @(negedge pclk_i);
    slv_wait = 100;
    drive(0, 1'b1, 1'b0, 1'b1, 8'h44, 32'h5555AAAA);
    @(negedge pclk_i);
    drive(0, 1'b1, 1'b1, 1'b1, 8'h44, 32'h5555AAAA);
    @(negedge pclk_i); #2;
    chk("t3_access", 32'({psel_o, penable_o}), 32'd3);
    preset_i = 1'b1;
    @(negedge pclk_i); #2;
    chk("t3_rst_psel",    32'(psel_o),    32'd0);
    chk("t3_rst_penable", 32'(penable_o), 32'd0);
    chk("t3_rst_grant",   32'(grant_o),   32'd0);
    chk("t3_rst_paddr",   32'(paddr_o),   32'd0);
    chk("t3_rst_ready",   32'({m0_pready_o, m1_pready_o}), 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge pclk_i);
    preset_i = 1'b0;
    slv_wait = 0;

    // simultaneous requests right after reset
    @(negedge pclk_i);
    fork
      xfer(0, 1'b1, 8'h30, 32'hA0A0A0A0, '0, 1'b0, lat0);
      xfer(1, 1'b1, 8'h31, 32'hB1B1B1B1, '0, 1'b0, lat1);
      begin
        @(negedge pclk_i); #2;
`ifdef APB_ARB_RR_EN
        chk("tie_first_grant", 32'(grant_o), 32'd2);
`else
        chk("tie_first_grant", 32'(grant_o), 32'd1);
`endif
        repeat (2) @(negedge pclk_i);
        #2;
        chk("tie_gap_grant", 32'(grant_o), 32'd0);
        chk("tie_gap_psel",  32'(psel_o),  32'd0);
        @(negedge pclk_i); #2;
`ifdef APB_ARB_RR_EN
        chk("tie_second_grant", 32'(grant_o), 32'd1);
`else
        chk("tie_second_grant", 32'(grant_o), 32'd2);
`endif
      end
    join
`ifdef APB_ARB_RR_EN
    chk("tie_lat_m1", 32'(lat1), 32'd2);
    chk("tie_lat_m0", 32'(lat0), 32'd5);
`else
    chk("tie_lat_m0", 32'(lat0), 32'd2);
    chk("tie_lat_m1", 32'(lat1), 32'd5);
`endif

    // slave error on m0 read
    @(negedge pclk_i);
    slv_err = 1'b1; slv_rdata = 32'hCAFE0001;
    xfer(0, 1'b0, 8'h50, '0, 32'hCAFE0001, 1'b1, lat);
    #2;
    chk("t5_latency",     32'(lat),          32'd2);
    chk("t5_err_dropped", 32'(m0_pslverr_o), 32'd0);
    slv_err = 1'b0;

    // m0 drops psel during SETUP: transfer still completes
    @(negedge pclk_i);
    slv_rdata = 32'h0BADF00D;
    push_exp(0, 1'b0, 8'h60, '0, '0, 1'b0, 1'b1);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h60, '0);
    @(negedge pclk_i); #2;
    chk("t6_setup", 32'({psel_o, penable_o}), 32'd2);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge pclk_i); #2;
    chk("t6_access", 32'({psel_o, penable_o}), 32'd3);
    chk("t6_paddr",  32'(paddr_o), 32'h60);
    @(negedge pclk_i); #2;
    chk("t6_idle", 32'({psel_o, grant_o}), 32'd0);

    repeat (2) @(negedge pclk_i);
    chk("sb_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
